// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state codes, opcodes,
// ALU/mux select encodings and a helper that identifies memory-wait states.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11,
        S_I_EXEC   = 4'd12,
        S_I_WB     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that hold a memory request open until mem_ready arrives
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on memory; expired flags the cycle
// in which the LIMIT-th waiting cycle would complete without a ready.
module mem_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Saturates at LIMIT so a held enable can never wrap back into range
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != CW'(LIMIT))) begin
            count <= count + CW'(1);
        end
    end

    assign expired = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main control FSM with memory-wait watchdog and retired counter.
// Define CTRL_ADDI_EN to add the addi (I_EXEC/I_WB) path; otherwise addi is illegal.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int TMO_CYC = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired
);

    state_t state_q, state_d;
    logic   retire, illegal_hit, tmo_expired, wait_en;

    assign wait_en = is_wait_state(state_q) && !mem_ready;
    assign state   = state_q;

    mem_wait_timer #(.LIMIT(TMO_CYC)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!wait_en),
        .en      (wait_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A ready arriving on the final allowed cycle takes priority over the watchdog
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        illegal_hit = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)        state_d = S_DECODE;
                else if (tmo_expired) state_d = S_HALT;
            end
            S_DECODE: begin
                case (op)
                    OP_W'(OP_RTYPE):            state_d = S_R_EXEC;
                    OP_W'(OP_LW), OP_W'(OP_SW): state_d = S_MEM_ADDR;
                    OP_W'(OP_BEQ):              state_d = S_BRANCH;
                    OP_W'(OP_J):                state_d = S_JUMP;
`ifdef CTRL_ADDI_EN
                    OP_W'(OP_ADDI):             state_d = S_I_EXEC;
`endif
                    default: begin
                        state_d     = S_HALT;
                        illegal_hit = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (op == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)        state_d = S_MEM_WB;
                else if (tmo_expired) state_d = S_HALT;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (tmo_expired) begin
                    state_d = S_HALT;
                end
            end
            S_R_EXEC: state_d = S_R_WB;
            S_I_EXEC: state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = SRCB_IMM_SH;
            S_MEM_ADDR, S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_I_WB:     reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
            retired     <= '0;
        end else begin
            if (illegal_hit) illegal_op  <= 1'b1;
            if (tmo_expired) mem_timeout <= 1'b1;
            if (retire)      retired     <= retired + CNT_W'(1);
        end
    end

endmodule
